fp_mul_arbiter: RTL and testbench

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

---
 rtl/fp_mul_arbiter.sv | 111 +++++++++++
 tb/tb_fp_mul_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined fp_mul between two requesters.
// Result ownership is tracked by a tag pipeline that advances with the multiplier.
module fp_mul_arbiter #(
  parameter int FLT_DATA_WIDTH = 32,
  parameter int MUL_LATENCY    = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      req0_valid,
  input  logic [FLT_DATA_WIDTH-1:0] req0_a,
  input  logic [FLT_DATA_WIDTH-1:0] req0_b,
  input  logic                      req1_valid,
  input  logic [FLT_DATA_WIDTH-1:0] req1_a,
  input  logic [FLT_DATA_WIDTH-1:0] req1_b,
  output logic                      req0_ready,
  output logic                      req1_ready,
  output logic                      res0_valid,
  output logic [FLT_DATA_WIDTH-1:0] res0_data,
  output logic                      res1_valid,
  output logic [FLT_DATA_WIDTH-1:0] res1_data,
  output logic [FLT_DATA_WIDTH-1:0] mul_dataa,
  output logic [FLT_DATA_WIDTH-1:0] mul_datab,
  output logic                      mul_clk_en,
  output logic                      mul_aclr,
  input  logic [FLT_DATA_WIDTH-1:0] mul_result,
  output logic                      busy
);

  // The product is valid after the MUL_LATENCY-th enabled edge past capture
  // and is registered on the following one, hence the extra tag slot.
  localparam int TAG_DEPTH = MUL_LATENCY + 1;

  logic                      last_grant_q, last_grant_d;
  logic [TAG_DEPTH-1:0]      tag_vld_q, tag_vld_d;
  logic [TAG_DEPTH-1:0]      tag_id_q, tag_id_d;
  logic                      res0_valid_q, res0_valid_d;
  logic                      res1_valid_q, res1_valid_d;
  logic [FLT_DATA_WIDTH-1:0] res0_data_q, res0_data_d;
  logic [FLT_DATA_WIDTH-1:0] res1_data_q, res1_data_d;
  logic                      gnt0, gnt1, issue;

  assign mul_clk_en = clk_en;
  assign mul_aclr   = rst;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (clk_en && !rst) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = ~last_grant_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign issue      = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign mul_dataa  = gnt0 ? req0_a : (gnt1 ? req1_a : '0);
  assign mul_datab  = gnt0 ? req0_b : (gnt1 ? req1_b : '0);

  always_comb begin
    last_grant_d = last_grant_q;
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    res0_valid_d = res0_valid_q;
    res1_valid_d = res1_valid_q;
    res0_data_d  = res0_data_q;
    res1_data_d  = res1_data_q;
    if (clk_en) begin
      if (issue) last_grant_d = gnt1;
      tag_vld_d    = {tag_vld_q[TAG_DEPTH-2:0], issue};
      tag_id_d     = {tag_id_q[TAG_DEPTH-2:0], gnt1};
      res0_valid_d = tag_vld_q[TAG_DEPTH-1] & ~tag_id_q[TAG_DEPTH-1];
      res1_valid_d = tag_vld_q[TAG_DEPTH-1] &  tag_id_q[TAG_DEPTH-1];
      if (res0_valid_d) res0_data_d = mul_result;
      if (res1_valid_d) res1_data_d = mul_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      res0_valid_q <= 1'b0;
      res1_valid_q <= 1'b0;
      res0_data_q  <= '0;
      res1_data_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      res0_valid_q <= res0_valid_d;
      res1_valid_q <= res1_valid_d;
      res0_data_q  <= res0_data_d;
      res1_data_q  <= res1_data_d;
    end
  end

  assign res0_valid = res0_valid_q;
  assign res1_valid = res1_valid_q;
  assign res0_data  = res0_data_q;
  assign res1_data  = res1_data_q;
  assign busy       = (|tag_vld_q) | res0_valid_q | res1_valid_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter with a behavioural pipelined fp_mul model.
module tb_fp_mul_arbiter;
  localparam int W = 32;
  localparam int L = 11;

  logic         clk, rst, clk_en;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         res0_valid, res1_valid;
  logic [W-1:0] res0_data, res1_data;
  logic [W-1:0] mul_dataa, mul_datab, mul_result;
  logic         mul_clk_en, mul_aclr, busy;

  fp_mul_arbiter #(.FLT_DATA_WIDTH(W), .MUL_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .res0_valid(res0_valid), .res0_data(res0_data),
    .res1_valid(res1_valid), .res1_data(res1_data),
    .mul_dataa(mul_dataa), .mul_datab(mul_datab),
    .mul_clk_en(mul_clk_en), .mul_aclr(mul_aclr),
    .mul_result(mul_result), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Known single-precision products of the directed vectors.
  function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
    case ({a, b})
      64'h40000000_40400000, 64'h40400000_40000000: fmul = 32'h40C00000;
      64'h40800000_3F000000, 64'h3F000000_40800000: fmul = 32'h40000000;
      64'h40400000_40400000:                        fmul = 32'h41100000;
      default:                                      fmul = 32'hFFFFFFFF;
    endcase
  endfunction

  // Multiplier model: product valid L enabled edges after operand capture.
  logic [W-1:0] mpipe [0:L];
  always @(posedge clk) begin
    if (mul_aclr) begin
      for (int i = 0; i <= L; i++) mpipe[i] <= '0;
    end else if (mul_clk_en) begin
      for (int i = L; i > 0; i--) mpipe[i] <= mpipe[i-1];
      mpipe[0] <= fmul(mul_dataa, mul_datab);
    end
  end
  assign mul_result = mpipe[L];

  int   cyc = 0;
  logic last_en = 1'b0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    last_en <= clk_en && !rst;
  end

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic         port;
    logic [W-1:0] data;
    int           at;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: one result per enabled edge, compared in issue order.
  always @(negedge clk) begin
    if (last_en && (res0_valid || res1_valid)) begin
      if (res0_valid && res1_valid) chk("both_res_valid", 64'd1, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {63'd0, res1_valid}, 64'd2);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_port", {63'd0, res1_valid}, {63'd0, e.port});
        chk("res_data", {32'd0, (res1_valid ? res1_data : res0_data)}, {32'd0, e.data});
        chk("res_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic drive(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic chk_ready(input string name, input logic e0, input logic e1);
    #1;
    chk({name, "_rdy0"}, {63'd0, req0_ready}, {63'd0, e0});
    chk({name, "_rdy1"}, {63'd0, req1_ready}, {63'd0, e1});
  endtask

  task automatic push(input logic port, input logic [W-1:0] data, input int stall);
    exp_t e;
    e.port = port;
    e.data = data;
    e.at   = cyc + 1 + L + 1 + stall;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) break;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clk_en = 1'b1;
    drive(1'b1, 32'h40000000, 32'h40400000, 1'b1, 32'h40400000, 32'h40400000);

    // Reset: outputs cleared, no grant while rst is high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_ready("rst_prio", 1'b0, 1'b0);
    chk("rst_res0_valid", {63'd0, res0_valid}, 64'd0);
    chk("rst_res1_valid", {63'd0, res1_valid}, 64'd0);
    chk("rst_res0_data", {32'd0, res0_data}, 64'd0);
    chk("rst_res1_data", {32'd0, res1_data}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_aclr", {63'd0, mul_aclr}, 64'd1);
    chk("rst_dataa_zero", {32'd0, mul_dataa}, 64'd0);

    // Single operation on req0: 2.0 * 3.0
    rst = 1'b0;
    drive(1'b1, 32'h40000000, 32'h40400000, 1'b0, '0, '0);
    chk_ready("single", 1'b1, 1'b0);
    chk("single_dataa", {32'd0, mul_dataa}, {32'd0, 32'h40000000});
    chk("single_datab", {32'd0, mul_datab}, {32'd0, 32'h40400000});
    chk("single_aclr", {63'd0, mul_aclr}, 64'd0);
    push(1'b0, 32'h40C00000, 0);
    @(negedge clk);
    idle();
    #1;
    chk("single_busy", {63'd0, busy}, 64'd1);
    chk("idle_dataa_zero", {32'd0, mul_dataa}, 64'd0);
    wait_idle("single");

    // Contention after reset: req0 wins first, then alternation
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h40800000, 32'h3F000000, 1'b1, 32'h40400000, 32'h40400000);
      chk_ready("contend", (k % 2) == 0, (k % 2) == 1);
      if ((k % 2) == 0) push(1'b0, 32'h40000000, 0);
      else              push(1'b1, 32'h41100000, 0);
      @(negedge clk);
    end
    idle();
    wait_idle("contend");

    // Stall: clk_en low for 3 cycles starting 4 cycles after issue
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b1, 32'h40400000, 32'h40400000);
    chk_ready("stall_issue", 1'b0, 1'b1);
    push(1'b1, 32'h41100000, 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      clk_en = 1'b0;
      drive(1'b1, 32'h40800000, 32'h3F000000, 1'b1, 32'h40400000, 32'h40400000);
      chk_ready("stall_hold", 1'b0, 1'b0);
      chk("stall_mul_clk_en", {63'd0, mul_clk_en}, 64'd0);
      chk("stall_busy", {63'd0, busy}, 64'd1);
    end
    @(negedge clk);
    clk_en = 1'b1;
    idle();
    wait_idle("stall");

    // Abort: reset 4 cycles after a req1 issue discards it
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b1, 32'h40400000, 32'h40400000);
    chk_ready("abort_issue", 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 32'h40400000, 32'h40400000);
    chk_ready("abort_rst", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_res1_valid", {63'd0, res1_valid}, 64'd0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b1, 32'h40400000, 32'h40400000);
    chk_ready("abort_reissue", 1'b0, 1'b1);
    push(1'b1, 32'h41100000, 0);
    @(negedge clk);
    idle();
    wait_idle("abort");

    // Work-conserving, back-to-back issues
    @(negedge clk);
    drive(1'b1, 32'h40800000, 32'h3F000000, 1'b0, '0, '0);
    chk_ready("wc_r0a", 1'b1, 1'b0);
    push(1'b0, 32'h40000000, 0);
    @(negedge clk);
    drive(1'b1, 32'h40000000, 32'h40400000, 1'b0, '0, '0);
    chk_ready("wc_r0b", 1'b1, 1'b0);
    push(1'b0, 32'h40C00000, 0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b1, 32'h40400000, 32'h40400000);
    chk_ready("wc_r1", 1'b0, 1'b1);
    push(1'b1, 32'h41100000, 0);
    @(negedge clk);
    drive(1'b1, 32'h40800000, 32'h3F000000, 1'b1, 32'h40400000, 32'h40400000);
    chk_ready("wc_rr", 1'b1, 1'b0);
    push(1'b0, 32'h40000000, 0);
    @(negedge clk);
    idle();
    wait_idle("wc");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
